multicycle_control_fsm: RTL

- Main controller for the multicycle RV32I core.
- Sequences the shared datapath (one memory, one ALU, PC/IR/register file) over several cycles per instruction, using a Moore state machine plus an ALU decoder.
- Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.
- Takes its opcode and function fields from the instruction register; drives all datapath enables and muxes.

---
 rtl/multicycle_control_fsm.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Main multicycle RV32I controller: Moore sequencer plus ALU decoder for the shared datapath.
// Optional memory handshake enabled with `define MULTICYCLE_MEM_READY_EN (adds mem_ready input).
module multicycle_control_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef MULTICYCLE_MEM_READY_EN
  input  logic       mem_ready,
`endif
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRtype = 7'b0110011;
  localparam logic [6:0] OpItype = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StHalt     = 4'd11
  } state_e;

  state_e     state_q, state_d;
  state_e     dec_state;
  logic       mem_rdy;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       ir_en;
  logic       mem_en;
  logic       reg_en;
  logic       done;
  logic       illegal;

`ifdef MULTICYCLE_MEM_READY_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   if (mem_rdy) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpJal:           state_d = StJal;
          OpBeq:           state_d = StBeq;
          default:         state_d = ILLEGAL_TRAP ? StHalt : StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_rdy) state_d = StMemWb;
      StMemWrite: if (mem_rdy) state_d = StFetch;
      StExecR, StExecI, StJal: state_d = StAluWb;
      StMemWb, StAluWb, StBeq: state_d = StFetch;
      StHalt:     state_d = StHalt;
      default:    state_d = StFetch;
    endcase
  end

  // While in reset the mux selects show the FETCH decode regardless of the held state.
  assign dec_state = rst_n ? state_q : StFetch;

  always_comb begin
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_en      = 1'b0;
    mem_en     = 1'b0;
    reg_en     = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (dec_state)
      StFetch: begin
        ir_en      = mem_rdy;
        pc_update  = mem_rdy;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OpLoad, OpStore, OpRtype, OpItype, OpJal, OpBeq: illegal = 1'b0;
          default:                                         illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        result_src = 2'b01;
        reg_en     = 1'b1;
        done       = 1'b1;
      end
      StMemWrite: begin
        adr_src = 1'b1;
        mem_en  = mem_rdy;
        done    = mem_rdy;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      StAluWb: begin
        reg_en = 1'b1;
        done   = 1'b1;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_write   = rst_n & (pc_update | (branch & zero));
    ir_write   = rst_n & ir_en;
    mem_write  = rst_n & mem_en;
    reg_write  = rst_n & reg_en;
    instr_done = rst_n & done;
    illegal_op = rst_n & illegal;
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  assign state = state_q;

endmodule
